mod_n_fsm_counter: RTL and testbench

- Parametrised successor to the team's fixed 4-state Moore counter FSM. Counts modulo MODULUS, up or down, with synchronous clear, parallel load, and wrap or saturate end behaviour.
- All status outputs are Moore: they decode from registered state only.
- Used as a programmable step/phase sequencer and terminal-count generator in lab datapaths.

---
 rtl/mod_n_fsm_counter_if.sv | 25 ++
 rtl/mod_n_fsm_counter.sv | 103 ++++++++++
 tb/tb_mod_n_fsm_counter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mod_n_fsm_counter_if.sv
// Control and status bundle for mod_n_fsm_counter.
// The master side drives the count controls; the slave side is the counter.
interface mod_n_fsm_counter_if #(
   parameter int WIDTH = 4
);
   logic             i_en;
   logic             i_dir;
   logic             i_clr;
   logic             i_load;
   logic [WIDTH-1:0] i_load_val;
   logic [WIDTH-1:0] state;
   logic             o_max;
   logic             o_min;
   logic             o_wrap;

   modport master (
      output i_en, i_dir, i_clr, i_load, i_load_val,
      input  state, o_max, o_min, o_wrap
   );

   modport slave (
      input  i_en, i_dir, i_clr, i_load, i_load_val,
      output state, o_max, o_min, o_wrap
   );
endinterface

// File: rtl/mod_n_fsm_counter.sv
// Modulo-MODULUS up/down counter with clear, clamped load and wrap/saturate ends.
// All status outputs decode from registered state only.
module mod_n_fsm_counter #(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 10,
   parameter int SATURATE = 0
) (
   input logic                 i_clk,
   input logic                 i_rst_n,
   mod_n_fsm_counter_if.slave  bus
);
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   typedef enum logic [2:0] {
      ACT_HOLD = 3'd0,
      ACT_FIX  = 3'd1,
      ACT_CLR  = 3'd2,
      ACT_LOAD = 3'd3,
      ACT_UP   = 3'd4,
      ACT_DOWN = 3'd5
   } action_t;

   logic [WIDTH-1:0] state_r;
   logic [WIDTH-1:0] state_nxt_s;
   logic             wrap_r;
   logic             wrap_nxt_s;
   logic             in_range_s;
   logic             load_ok_s;
   action_t          action_s;

   // Range checks are done in 32 bits so they stay meaningful when MODULUS == 2^WIDTH.
   always_comb begin
      in_range_s = ({{(32-WIDTH){1'b0}}, state_r} <= 32'(MODULUS - 1));
      load_ok_s  = ({{(32-WIDTH){1'b0}}, bus.i_load_val} <= 32'(MODULUS - 1));
   end

   // Select this edge's action: illegal state recovery first, then clr > load > en.
   always_comb begin
      action_s = ACT_HOLD;
      if (!in_range_s) begin
         action_s = ACT_FIX;
      end else if (bus.i_clr) begin
         action_s = ACT_CLR;
      end else if (bus.i_load) begin
         action_s = ACT_LOAD;
      end else if (bus.i_en) begin
         action_s = bus.i_dir ? ACT_UP : ACT_DOWN;
      end else begin
         action_s = ACT_HOLD;
      end
   end

   // Next count and wrap flag; the ends compare against MAX_VAL and never rely on overflow.
   always_comb begin
      state_nxt_s = state_r;
      wrap_nxt_s  = 1'b0;
      case (action_s)
         ACT_HOLD: state_nxt_s = state_r;
         ACT_FIX:  state_nxt_s = ZERO;
         ACT_CLR:  state_nxt_s = ZERO;
         ACT_LOAD: state_nxt_s = load_ok_s ? bus.i_load_val : MAX_VAL;
         ACT_UP: begin
            if (state_r != MAX_VAL) begin
               state_nxt_s = state_r + ONE;
            end else if (SATURATE == 0) begin
               state_nxt_s = ZERO;
               wrap_nxt_s  = 1'b1;
            end else begin
               state_nxt_s = state_r;
            end
         end
         ACT_DOWN: begin
            if (state_r != ZERO) begin
               state_nxt_s = state_r - ONE;
            end else if (SATURATE == 0) begin
               state_nxt_s = MAX_VAL;
               wrap_nxt_s  = 1'b1;
            end else begin
               state_nxt_s = state_r;
            end
         end
         default: state_nxt_s = ZERO;
      endcase
   end

   // Count and wrap registers; reset aborts any pending step and in-flight wrap pulse.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= ZERO;
         wrap_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         wrap_r  <= wrap_nxt_s;
      end
   end

   assign bus.state  = state_r;
   assign bus.o_max  = (state_r == MAX_VAL);
   assign bus.o_min  = (state_r == ZERO);
   assign bus.o_wrap = wrap_r;
endmodule

// File: tb/tb_mod_n_fsm_counter.sv
// Directed bench: three counter configurations (mod-10 wrap, mod-10 saturate, mod-2 wrap)
// share one clock and reset; expected values are computed from the counting rules.
module tb_mod_n_fsm_counter;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   mod_n_fsm_counter_if #(.WIDTH(4)) bus_a ();
   mod_n_fsm_counter_if #(.WIDTH(4)) bus_b ();
   mod_n_fsm_counter_if #(.WIDTH(1)) bus_c ();

   mod_n_fsm_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_a (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus_a.slave));
   mod_n_fsm_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus_b.slave));
   mod_n_fsm_counter #(.WIDTH(1), .MODULUS(2), .SATURATE(0)) u_c (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus_c.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      if (obs !== exp) begin
         errors = errors + 1;
         $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_s;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus_a.i_en = 1'b0; bus_a.i_dir = 1'b1; bus_a.i_clr = 1'b0; bus_a.i_load = 1'b0; bus_a.i_load_val = 4'd0;
      bus_b.i_en = 1'b0; bus_b.i_dir = 1'b1; bus_b.i_clr = 1'b0; bus_b.i_load = 1'b0; bus_b.i_load_val = 4'd0;
      bus_c.i_en = 1'b0; bus_c.i_dir = 1'b1; bus_c.i_clr = 1'b0; bus_c.i_load = 1'b0; bus_c.i_load_val = 1'b0;

      // reset state, before any clock edge
      #1;
      check("rst_state", 32'(bus_a.state), 32'd0);
      check("rst_min", 32'(bus_a.o_min), 32'd1);
      check("rst_max", 32'(bus_a.o_max), 32'd0);
      check("rst_wrap", 32'(bus_a.o_wrap), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // mod-10 wrap, counting up 12 clocks
      bus_a.i_en = 1'b1;
      bus_a.i_dir = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         exp_s = k % 10;
         check("up_state", 32'(bus_a.state), 32'(exp_s));
         check("up_max", 32'(bus_a.o_max), 32'(exp_s == 9));
         check("up_wrap", 32'(bus_a.o_wrap), 32'(k == 10));
      end
      bus_a.i_en = 1'b0;
      tick();
      check("hold_state", 32'(bus_a.state), 32'd2);
      check("hold_wrap", 32'(bus_a.o_wrap), 32'd0);

      // clear, then count down through zero
      bus_a.i_clr = 1'b1;
      tick();
      check("clr_state", 32'(bus_a.state), 32'd0);
      check("clr_min", 32'(bus_a.o_min), 32'd1);
      bus_a.i_clr = 1'b0;
      bus_a.i_en = 1'b1;
      bus_a.i_dir = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         check("dn_state", 32'(bus_a.state), 32'(10 - k));
         check("dn_wrap", 32'(bus_a.o_wrap), 32'(k == 1));
         check("dn_min", 32'(bus_a.o_min), 32'd0);
      end
      bus_a.i_en = 1'b0;

      // saturating counter: up then down 12 clocks each
      bus_b.i_en = 1'b1;
      bus_b.i_dir = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         exp_s = (k > 9) ? 9 : k;
         check("sat_up_state", 32'(bus_b.state), 32'(exp_s));
         check("sat_up_max", 32'(bus_b.o_max), 32'(exp_s == 9));
         check("sat_up_wrap", 32'(bus_b.o_wrap), 32'd0);
      end
      bus_b.i_dir = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         exp_s = (k > 9) ? 0 : 9 - k;
         check("sat_dn_state", 32'(bus_b.state), 32'(exp_s));
         check("sat_dn_wrap", 32'(bus_b.o_wrap), 32'd0);
      end
      check("sat_dn_min", 32'(bus_b.o_min), 32'd1);
      bus_b.i_en = 1'b0;

      // load, clamped load, and clr/load/en collision
      bus_a.i_load = 1'b1;
      bus_a.i_load_val = 4'd6;
      tick();
      check("load6", 32'(bus_a.state), 32'd6);
      bus_a.i_load_val = 4'd14;
      tick();
      check("load14_clamp", 32'(bus_a.state), 32'd9);
      check("load_max", 32'(bus_a.o_max), 32'd1);
      bus_a.i_clr = 1'b1;
      bus_a.i_load_val = 4'd3;
      bus_a.i_en = 1'b1;
      bus_a.i_dir = 1'b1;
      tick();
      check("clr_prio", 32'(bus_a.state), 32'd0);
      check("clr_prio_wrap", 32'(bus_a.o_wrap), 32'd0);
      bus_a.i_clr = 1'b0;
      bus_a.i_en = 1'b0;
      bus_a.i_load_val = 4'd4;
      tick();
      check("load4", 32'(bus_a.state), 32'd4);

      // async reset mid-cycle at state 5
      bus_a.i_load = 1'b0;
      bus_a.i_en = 1'b1;
      tick();
      check("pre_rst_state", 32'(bus_a.state), 32'd5);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_state", 32'(bus_a.state), 32'd0);
      check("async_rst_wrap", 32'(bus_a.o_wrap), 32'd0);
      check("async_rst_min", 32'(bus_a.o_min), 32'd1);
      tick();
      check("rst_edge_nocount", 32'(bus_a.state), 32'd0);
      #2;
      rst_n = 1'b1;
      tick();
      check("resume_state", 32'(bus_a.state), 32'd1);
      bus_a.i_en = 1'b0;

      // mod-2 toggling
      bus_c.i_en = 1'b1;
      bus_c.i_dir = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         exp_s = k % 2;
         check("m2_state", 32'(bus_c.state), 32'(exp_s));
         check("m2_wrap", 32'(bus_c.o_wrap), 32'(exp_s == 0));
         check("m2_max", 32'(bus_c.o_max), 32'(exp_s == 1));
         check("m2_min", 32'(bus_c.o_min), 32'(exp_s == 0));
      end
      bus_c.i_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
